// File: rtl/pipe_skid_reg_pkg.sv
// pipe_pkg: shared state encoding and default payload width for pipe_skid_reg
package pipe_pkg;
  localparam int PIPE_DATA_W = 64;
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;
endpackage

// File: rtl/pipe_skid_reg_if.sv
// pipe_skid_reg_if: valid/ready handshake bundle, flush and occupancy of a pipeline stage
interface pipe_skid_reg_if import pipe_pkg::*; #(parameter int DATA_W = PIPE_DATA_W);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;
  modport master (output flush, in_valid, in_data, out_ready, input in_ready, out_valid, out_data, occupancy);
  modport slave  (input flush, in_valid, in_data, out_ready, output in_ready, out_valid, out_data, occupancy);
endinterface

// File: rtl/pipe_skid_reg_sat_cnt.sv
// pipe_sat_cnt: counter that increments on inc and sticks at all-ones
module pipe_sat_cnt #(parameter int W = 32) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  // count up until saturated; only reset clears
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else if (inc && cnt != '1) cnt <= cnt + W'(1);
endmodule

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: elastic stage register with 2-entry skid buffer; PIPE_STATS_EN adds stall/flush counters
module pipe_skid_reg import pipe_pkg::*; #(
  parameter int DATA_W   = PIPE_DATA_W,
  parameter bit CLR_DATA = 1'b1,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  pipe_skid_reg_if.slave   bus
`ifdef PIPE_STATS_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);
  state_t            st;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;
  logic              push;
  logic              pop;
  assign bus.out_valid = st != ST_EMPTY;
  assign bus.in_ready  = st != ST_TWO;
  assign bus.occupancy = st;
  assign bus.out_data  = main_q;
  assign push = bus.in_valid & bus.in_ready;
  assign pop  = bus.out_valid & bus.out_ready;
  // occupancy FSM with main/skid payload registers; flush overrides any handshake
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      st     <= ST_EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else if (bus.flush) begin
      st <= ST_EMPTY;
      if (CLR_DATA) begin
        main_q <= '0;
        skid_q <= '0;
      end
    end else begin
      case (st)
        ST_EMPTY:
          if (push) begin
            st     <= ST_ONE;
            main_q <= bus.in_data;
          end
        ST_ONE:
          if (push && pop) main_q <= bus.in_data;
          else if (push) begin
            st     <= ST_TWO;
            skid_q <= bus.in_data;
          end else if (pop) begin
            st <= ST_EMPTY;
            if (CLR_DATA) main_q <= '0;
          end
        ST_TWO:
          if (pop) begin
            st     <= ST_ONE;
            main_q <= skid_q;
            if (CLR_DATA) skid_q <= '0;
          end
        default: st <= ST_EMPTY;
      endcase
    end
`ifdef PIPE_STATS_EN
  pipe_sat_cnt #(.W(CNT_W)) u_stall (
    .clk   (clk),
    .reset (reset),
    .inc   (bus.out_valid & ~bus.out_ready & ~bus.flush),
    .cnt   (stall_cnt)
  );
  pipe_sat_cnt #(.W(CNT_W)) u_flush (
    .clk   (clk),
    .reset (reset),
    .inc   (bus.flush & (st != ST_EMPTY)),
    .cnt   (flush_cnt)
  );
`endif
endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
- Parametrised elastic pipeline stage register, successor to the fixed D/E/M/W stage registers.
- Carries an arbitrary-width payload, such as {instr, pc4}, between pipeline stages using a valid/ready handshake.
- A 2-entry skid buffer keeps in_ready registered, so backpressure never forms a combinational path upstream.
- flush turns the stage into a bubble.

Parameters:
DATA_W, 64, payload width in bits (e.g. instr 32 + pc4 32).
CLR_DATA, 1, 1: payload registers zeroed whenever the stage empties (bubble = 0 = MIPS nop); 0: stale data held.
CNT_W, 32, width of the statistics counters (optional feature only).

Ports:
clk  input  1  clock, all state updates on rising edge.
reset  input  1  asynchronous, active-high reset.
flush  input  1  synchronous clear of the stage (branch/jump/hazard kill).
in_valid  input  1  upstream payload valid.
in_ready  output  1  stage can accept; registered, equals (occupancy != 2).
in_data  input  DATA_W  upstream payload.
out_valid  output  1  main register holds valid payload.
out_ready  input  1  downstream accepts this cycle.
out_data  output  DATA_W  main register contents.
occupancy  output  2  entries held: 0, 1 or 2.

Behaviour:
- Definitions: push = in_valid & in_ready; pop = out_valid & out_ready.
- State encoding: EMPTY (0 entries), ONE (main full), TWO (main + skid full).
- Reset (async, active-high):
  - State goes to EMPTY; main and skid registers are 0.
  - out_valid = 0, in_ready = 1, occupancy = 0, out_data = 0.
- Flush (synchronous) has priority over push and pop.
  - Next state is EMPTY and all entries are dropped.
  - A push in the same cycle is discarded even though in_ready was 1.
  - If CLR_DATA=1, main and skid are zeroed.
- Transitions when flush = 0:
  - EMPTY: push -> ONE, main <= in_data. Otherwise stay.
  - ONE: push & pop -> ONE, main <= in_data.
  - ONE: push & !pop -> TWO, skid <= in_data.
  - ONE: pop & !push -> EMPTY; main zeroed if CLR_DATA=1.
  - ONE: neither -> hold.
  - TWO: push is impossible (in_ready=0). pop -> ONE, main <= skid; skid zeroed if CLR_DATA=1. Otherwise hold.
- Latency: 1 cycle from push to out_valid when EMPTY, or when ONE with a simultaneous pop.
- Ordering: strictly FIFO. The skid entry is never presented before main.
- Outputs out_valid, in_ready and occupancy are pure decodes of the state register; no input reaches any output combinationally.
- Full (TWO) with out_ready held low: both entries are held indefinitely and in_ready stays 0.
- Empty with out_ready high: no state change.
- Reset asserted mid-transfer: contents are lost immediately; there is no partial update.

Optional Feature:
PIPE_STATS_EN
- Defined: adds outputs stall_cnt [CNT_W] and flush_cnt [CNT_W].
  - stall_cnt increments each cycle with out_valid & !out_ready & !flush.
  - flush_cnt increments each cycle flush is high while occupancy != 0.
  - Both saturate at all-ones, are cleared only by reset, and read 0 after reset.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package pipe_pkg holds:
  - the state encoding localparams ST_EMPTY=2'd0, ST_ONE=2'd1, ST_TWO=2'd2;
  - the default payload width constant.
- One natural sub-module, pipe_sat_cnt (width-parametrised saturating counter with inc input). It is instantiated twice, only under PIPE_STATS_EN.

Test Plan:
1. Reset: assert reset mid-cycle with in_valid=1 -> out_valid=0, in_ready=1, occupancy=0, out_data=0 immediately (async).
2. Streaming: out_ready=1, push 0xA,0xB,0xC on consecutive cycles -> out_data 0xA,0xB,0xC one cycle after each push; occupancy stays 1; in_ready stays 1.
3. Backpressure: out_ready=0, push 0x11 then 0x22 -> occupancy 2, in_ready=0. Raise out_ready -> outputs 0x11, then 0x22, then out_valid=0; in_ready returns 1 the cycle after the first pop.
4. Flush priority: in state TWO, drive flush=1 with out_ready=1 -> next cycle occupancy=0, out_valid=0, out_data=0 (CLR_DATA=1). Flush in EMPTY with push 0x33 -> 0x33 is dropped.
5. CLR_DATA=0: pop to EMPTY after 0x44 -> out_valid=0, out_data still 0x44.
6. PIPE_STATS_EN with CNT_W=4: hold out_valid with out_ready=0 for 20 cycles -> stall_cnt saturates at 15. Three flushes with occupancy != 0 -> flush_cnt=3.
